// File: rtl/id_ex_stage_pkg.sv
// Shared constants for the ID/EX stage: widths, opcodes, zero register, forward selects.
package id_ex_stage_pkg;

    localparam int DSIZE    = 16;
    localparam int RSIZE    = 4;
    localparam int OPW      = 4;
    localparam int REG_ZERO = 0;

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_AND  = 4'd2,
        OP_XOR  = 4'd3,
        OP_COM  = 4'd4,
        OP_MUL  = 4'd5,
        OP_ADDI = 4'd6,
        OP_LW   = 4'd7,
        OP_SW   = 4'd8
    } op_e;

    typedef enum logic [1:0] {
        SEL_REG = 2'd0,
        SEL_EXM = 2'd1,
        SEL_WB  = 2'd2
    } fwd_sel_e;

endpackage

// File: rtl/id_ex_stage_fwd_mux.sv
// Operand forwarding mux for one source register: EX/MEM beats MEM/WB beats the register file.
module id_ex_stage_fwd_mux
    import id_ex_stage_pkg::*;
#(
    parameter int DW = DSIZE,
    parameter int RW = RSIZE
) (
    input  logic          fwd_en,
    input  logic [RW-1:0] src,
    input  logic [DW-1:0] reg_data,
    input  logic          exm_wen,
    input  logic          exm_is_load,
    input  logic [RW-1:0] exm_rd,
    input  logic [DW-1:0] exm_result,
    input  logic          wb_wen,
    input  logic [RW-1:0] wb_rd,
    input  logic [DW-1:0] wb_data,
    output logic [DW-1:0] value,
    output fwd_sel_e      sel
);

    logic src_live;

    always_comb begin
        src_live = (src != RW'(REG_ZERO));
        sel      = SEL_REG;
        value    = reg_data;
        // A load in EX/MEM has no data yet; its value only becomes visible from MEM/WB.
        if (fwd_en && src_live && exm_wen && !exm_is_load && (exm_rd == src)) begin
            sel   = SEL_EXM;
            value = exm_result;
        end else if (fwd_en && src_live && wb_wen && (wb_rd == src)) begin
            sel   = SEL_WB;
            value = wb_data;
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand forwarding and hazard stall.
// Define ID_EX_FORWARD_EN for forwarding + load-use stall; otherwise every RAW hazard stalls.
module id_ex_stage #(
    parameter int DSIZE = id_ex_stage_pkg::DSIZE,
    parameter int RSIZE = id_ex_stage_pkg::RSIZE,
    parameter int OPW   = id_ex_stage_pkg::OPW
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [OPW-1:0]   id_op,
    input  logic [RSIZE-1:0] id_rs1,
    input  logic [RSIZE-1:0] id_rs2,
    input  logic [RSIZE-1:0] id_rd,
    input  logic             id_rs1_used,
    input  logic             id_rs2_used,
    input  logic [DSIZE-1:0] id_rd1,
    input  logic [DSIZE-1:0] id_rd2,
    input  logic [DSIZE-1:0] id_imm,
    input  logic             id_use_imm,
    input  logic             id_wen,
    input  logic             id_is_load,
    input  logic             id_is_store,
    input  logic             exm_wen,
    input  logic             exm_is_load,
    input  logic [RSIZE-1:0] exm_rd,
    input  logic [DSIZE-1:0] exm_result,
    input  logic             wb_wen,
    input  logic [RSIZE-1:0] wb_rd,
    input  logic [DSIZE-1:0] wb_data,
    input  logic             flush,
    output logic             stall,
    output logic             ex_valid,
    output logic             ex_wen,
    output logic             ex_is_load,
    output logic             ex_is_store,
    output logic [OPW-1:0]   ex_op,
    output logic [RSIZE-1:0] ex_rd,
    output logic [DSIZE-1:0] ex_a,
    output logic [DSIZE-1:0] ex_b,
    output logic [DSIZE-1:0] ex_store_data,
    output logic [3:0]       fwd_sel
);
    import id_ex_stage_pkg::*;

    logic [DSIZE-1:0] rd1_q, rd2_q, imm_q;
    logic [RSIZE-1:0] rs1_q, rs2_q;
    logic             use_imm_q;
    logic             hazard;
    logic             bubble;
    logic [DSIZE-1:0] a_fwd, b_fwd;
    fwd_sel_e         a_sel, b_sel;

`ifdef ID_EX_FORWARD_EN
    localparam logic FWD_ON = 1'b1;

    // Only a load in EX cannot be forwarded in time; one bubble lets it reach MEM/WB.
    always_comb begin
        hazard = ex_valid && ex_is_load && (ex_rd != RSIZE'(REG_ZERO)) &&
                 ((id_rs1_used && (id_rs1 == ex_rd)) || (id_rs2_used && (id_rs2 == ex_rd)));
    end
`else
    localparam logic FWD_ON = 1'b0;

    logic hit1, hit2;

    // Without forwarding, any in-flight writer of a used source holds decode.
    always_comb begin
        hit1 = (id_rs1 != RSIZE'(REG_ZERO)) &&
               ((ex_valid && ex_wen && (ex_rd == id_rs1)) ||
                (exm_wen && (exm_rd == id_rs1)) ||
                (wb_wen && (wb_rd == id_rs1)));
        hit2 = (id_rs2 != RSIZE'(REG_ZERO)) &&
               ((ex_valid && ex_wen && (ex_rd == id_rs2)) ||
                (exm_wen && (exm_rd == id_rs2)) ||
                (wb_wen && (wb_rd == id_rs2)));
        hazard = (id_rs1_used && hit1) || (id_rs2_used && hit2);
    end
`endif

    assign stall  = !rst && hazard;
    assign bubble = rst || flush || stall || !id_valid;

    always_ff @(posedge clk) begin
        if (bubble) begin
            ex_valid    <= 1'b0;
            ex_wen      <= 1'b0;
            ex_is_load  <= 1'b0;
            ex_is_store <= 1'b0;
            ex_op       <= '0;
            ex_rd       <= '0;
            rs1_q       <= '0;
            rs2_q       <= '0;
            rd1_q       <= '0;
            rd2_q       <= '0;
            imm_q       <= '0;
            use_imm_q   <= 1'b0;
        end else begin
            ex_valid    <= 1'b1;
            ex_wen      <= id_wen;
            ex_is_load  <= id_is_load;
            ex_is_store <= id_is_store;
            ex_op       <= id_op;
            ex_rd       <= id_rd;
            rs1_q       <= id_rs1;
            rs2_q       <= id_rs2;
            rd1_q       <= id_rd1;
            rd2_q       <= id_rd2;
            imm_q       <= id_imm;
            use_imm_q   <= id_use_imm;
        end
    end

    id_ex_stage_fwd_mux #(.DW(DSIZE), .RW(RSIZE)) u_fwd_a (
        .fwd_en      (FWD_ON),
        .src         (rs1_q),
        .reg_data    (rd1_q),
        .exm_wen     (exm_wen),
        .exm_is_load (exm_is_load),
        .exm_rd      (exm_rd),
        .exm_result  (exm_result),
        .wb_wen      (wb_wen),
        .wb_rd       (wb_rd),
        .wb_data     (wb_data),
        .value       (a_fwd),
        .sel         (a_sel)
    );

    id_ex_stage_fwd_mux #(.DW(DSIZE), .RW(RSIZE)) u_fwd_b (
        .fwd_en      (FWD_ON),
        .src         (rs2_q),
        .reg_data    (rd2_q),
        .exm_wen     (exm_wen),
        .exm_is_load (exm_is_load),
        .exm_rd      (exm_rd),
        .exm_result  (exm_result),
        .wb_wen      (wb_wen),
        .wb_rd       (wb_rd),
        .wb_data     (wb_data),
        .value       (b_fwd),
        .sel         (b_sel)
    );

    assign ex_a          = a_fwd;
    assign ex_b          = use_imm_q ? imm_q : b_fwd;
    assign ex_store_data = b_fwd;
    assign fwd_sel       = {b_sel, a_sel};

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage; forwarding vectors apply when ID_EX_FORWARD_EN is defined.
module tb_id_ex_stage;

    localparam logic [3:0] ADD  = 4'd0;
    localparam logic [3:0] SUB  = 4'd1;
    localparam logic [3:0] ADDI = 4'd6;
    localparam logic [3:0] LW   = 4'd7;
    localparam logic [3:0] SW   = 4'd8;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid;
    logic [3:0]  id_op, id_rs1, id_rs2, id_rd;
    logic        id_rs1_used, id_rs2_used;
    logic [15:0] id_rd1, id_rd2, id_imm;
    logic        id_use_imm, id_wen, id_is_load, id_is_store;
    logic        exm_wen, exm_is_load;
    logic [3:0]  exm_rd;
    logic [15:0] exm_result;
    logic        wb_wen;
    logic [3:0]  wb_rd;
    logic [15:0] wb_data;
    logic        flush;
    logic        stall;
    logic        ex_valid, ex_wen, ex_is_load, ex_is_store;
    logic [3:0]  ex_op, ex_rd;
    logic [15:0] ex_a, ex_b, ex_store_data;
    logic [3:0]  fwd_sel;

    typedef struct packed {
        logic        v;
        logic        wen;
        logic        ld;
        logic        st;
        logic [3:0]  op;
        logic [3:0]  rd;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] sd;
        logic        stl;
        logic [3:0]  sel;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;
    int   n_pass = 0;
    int   n_total = 0;
    int   cyc = 0;

    id_ex_stage dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_op(id_op),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
        .id_rd1(id_rd1), .id_rd2(id_rd2), .id_imm(id_imm), .id_use_imm(id_use_imm),
        .id_wen(id_wen), .id_is_load(id_is_load), .id_is_store(id_is_store),
        .exm_wen(exm_wen), .exm_is_load(exm_is_load), .exm_rd(exm_rd), .exm_result(exm_result),
        .wb_wen(wb_wen), .wb_rd(wb_rd), .wb_data(wb_data), .flush(flush),
        .stall(stall), .ex_valid(ex_valid), .ex_wen(ex_wen), .ex_is_load(ex_is_load),
        .ex_is_store(ex_is_store), .ex_op(ex_op), .ex_rd(ex_rd), .ex_a(ex_a), .ex_b(ex_b),
        .ex_store_data(ex_store_data), .fwd_sel(fwd_sel)
    );

    // Clock
    always #5 clk = ~clk;

    // Driver tasks
    task automatic clr();
        rst = 1'b0; flush = 1'b0;
        id_valid = 1'b0; id_op = '0; id_rs1 = '0; id_rs2 = '0; id_rd = '0;
        id_rs1_used = 1'b0; id_rs2_used = 1'b0; id_rd1 = '0; id_rd2 = '0; id_imm = '0;
        id_use_imm = 1'b0; id_wen = 1'b0; id_is_load = 1'b0; id_is_store = 1'b0;
        exm_wen = 1'b0; exm_is_load = 1'b0; exm_rd = '0; exm_result = '0;
        wb_wen = 1'b0; wb_rd = '0; wb_data = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        clr();
    endtask

    task automatic id_set(input logic [3:0] op, rd, rs1, rs2, input logic u1, u2,
                          input logic [15:0] d1, d2, imm, input logic ui, wen, ld, st);
        id_valid = 1'b1; id_op = op; id_rd = rd; id_rs1 = rs1; id_rs2 = rs2;
        id_rs1_used = u1; id_rs2_used = u2; id_rd1 = d1; id_rd2 = d2; id_imm = imm;
        id_use_imm = ui; id_wen = wen; id_is_load = ld; id_is_store = st;
    endtask

    task automatic exm_set(input logic wen, ld, input logic [3:0] rd, input logic [15:0] res);
        exm_wen = wen; exm_is_load = ld; exm_rd = rd; exm_result = res;
    endtask

    task automatic wb_set(input logic wen, input logic [3:0] rd, input logic [15:0] data);
        wb_wen = wen; wb_rd = rd; wb_data = data;
    endtask

    task automatic expect_out(input logic v, wen, ld, st, input logic [3:0] op, rd,
                              input logic [15:0] a, b, sd, input logic stl, input logic [3:0] sel);
        exp_t x;
        x.v = v; x.wen = wen; x.ld = ld; x.st = st; x.op = op; x.rd = rd;
        x.a = a; x.b = b; x.sd = sd; x.stl = stl; x.sel = sel;
        exp_q.push_back(x);
    endtask

    task automatic exp_bubble(input logic stl);
        expect_out(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 16'd0, 16'd0, 16'd0, stl, 4'd0);
    endtask

    // Scoreboard
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        n_total++;
        if (act === want) n_pass++;
        else $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, want);
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("ex_valid",      32'(ex_valid),      32'(e.v));
            chk("ex_wen",        32'(ex_wen),        32'(e.wen));
            chk("ex_is_load",    32'(ex_is_load),    32'(e.ld));
            chk("ex_is_store",   32'(ex_is_store),   32'(e.st));
            chk("ex_op",         32'(ex_op),         32'(e.op));
            chk("ex_rd",         32'(ex_rd),         32'(e.rd));
            chk("ex_a",          32'(ex_a),          32'(e.a));
            chk("ex_b",          32'(ex_b),          32'(e.b));
            chk("ex_store_data", 32'(ex_store_data), 32'(e.sd));
            chk("stall",         32'(stall),         32'(e.stl));
            chk("fwd_sel",       32'(fwd_sel),       32'(e.sel));
        end
    end

    // Stimulus
    initial begin
        clr();
        rst = 1'b1;
        repeat (2) @(posedge clk);

        // Reset dominates a valid decode slot
        tick(); rst = 1'b1; id_set(ADD, 1, 2, 3, 1, 1, 16'h0011, 16'h0022, 0, 0, 1, 0, 0);
        exp_bubble(0);
        tick(); id_set(ADD, 1, 2, 3, 1, 1, 16'h0011, 16'h0022, 0, 0, 1, 0, 0);
        exp_bubble(0);
        tick(); id_set(SUB, 5, 6, 7, 1, 1, 16'h0100, 16'h0030, 0, 0, 1, 0, 0);
        expect_out(1, 1, 0, 0, ADD, 1, 16'h0011, 16'h0022, 16'h0022, 0, 0);
        // rs2 field matches ex_rd but is unused: no stall
        tick(); id_set(ADDI, 8, 9, 5, 1, 0, 16'h0005, 16'h0abc, 16'hfff0, 1, 1, 0, 0);
        expect_out(1, 1, 0, 0, SUB, 5, 16'h0100, 16'h0030, 16'h0030, 0, 0);
        tick(); id_set(ADD, 10, 11, 12, 1, 1, 16'h1111, 16'h2222, 0, 0, 1, 0, 0); id_valid = 1'b0;
        expect_out(1, 1, 0, 0, ADDI, 8, 16'h0005, 16'hfff0, 16'h0abc, 0, 0);
        tick(); id_set(SW, 0, 2, 3, 1, 1, 16'h0040, 16'hbeef, 0, 0, 0, 0, 1);
        exp_bubble(0);
        tick();
        expect_out(1, 0, 0, 1, SW, 0, 16'h0040, 16'hbeef, 16'hbeef, 0, 0);

        // Register zero is never forwarded nor a hazard
        tick(); id_set(ADD, 6, 0, 0, 1, 1, 16'h0007, 16'h0009, 0, 0, 1, 0, 0);
        exm_set(1, 0, 0, 16'hffff); wb_set(1, 0, 16'hffff);
        exp_bubble(0);
        tick(); exm_set(1, 0, 0, 16'hffff); wb_set(1, 0, 16'hffff);
        expect_out(1, 1, 0, 0, ADD, 6, 16'h0007, 16'h0009, 16'h0009, 0, 0);

        // Plain flush
        tick(); id_set(ADD, 2, 3, 4, 1, 1, 16'h0033, 16'h0044, 0, 0, 1, 0, 0); flush = 1'b1;
        exp_bubble(0);
        tick();
        exp_bubble(0);

        // Load-use stall together with flush, then reset while a load sits in EX
        tick(); id_set(LW, 4, 5, 0, 1, 0, 16'h0100, 16'h0000, 16'h0004, 1, 1, 1, 0);
        exp_bubble(0);
        tick(); id_set(ADD, 6, 4, 2, 1, 1, 16'h0000, 16'h0022, 0, 0, 1, 0, 0); flush = 1'b1;
        expect_out(1, 1, 1, 0, LW, 4, 16'h0100, 16'h0004, 16'h0000, 1, 0);
        tick(); id_set(ADD, 6, 4, 2, 1, 1, 16'h0000, 16'h0022, 0, 0, 1, 0, 0);
        exp_bubble(0);
        tick(); id_set(LW, 4, 5, 0, 1, 0, 16'h0100, 16'h0000, 16'h0004, 1, 1, 1, 0);
        expect_out(1, 1, 0, 0, ADD, 6, 16'h0000, 16'h0022, 16'h0022, 0, 0);
        tick(); rst = 1'b1; id_set(ADD, 6, 4, 2, 1, 1, 16'h0000, 16'h0022, 0, 0, 1, 0, 0);
        expect_out(1, 1, 1, 0, LW, 4, 16'h0100, 16'h0004, 16'h0000, 0, 0);
        tick(); id_set(ADD, 6, 4, 2, 1, 1, 16'h0000, 16'h0022, 0, 0, 1, 0, 0);
        exp_bubble(0);
        tick();
        expect_out(1, 1, 0, 0, ADD, 6, 16'h0000, 16'h0022, 16'h0022, 0, 0);

`ifdef ID_EX_FORWARD_EN
        // EX/MEM forward onto both operands
        tick(); id_set(ADD, 1, 2, 3, 1, 1, 16'h0002, 16'h0003, 0, 0, 1, 0, 0);
        exp_bubble(0);
        tick(); id_set(ADD, 2, 1, 1, 1, 1, 16'h0000, 16'h0000, 0, 0, 1, 0, 0);
        expect_out(1, 1, 0, 0, ADD, 1, 16'h0002, 16'h0003, 16'h0003, 0, 0);
        tick(); id_set(ADD, 7, 3, 0, 1, 0, 16'h0001, 16'h0002, 0, 0, 1, 0, 0);
        exm_set(1, 0, 1, 16'h0005);
        expect_out(1, 1, 0, 0, ADD, 2, 16'h0005, 16'h0005, 16'h0005, 0, 4'b0101);
        // EX/MEM beats MEM/WB, then MEM/WB alone
        tick(); id_set(ADD, 7, 3, 0, 1, 0, 16'h0001, 16'h0002, 0, 0, 1, 0, 0);
        exm_set(1, 0, 3, 16'h0009); wb_set(1, 3, 16'h0007);
        expect_out(1, 1, 0, 0, ADD, 7, 16'h0009, 16'h0002, 16'h0002, 0, 4'b0001);
        tick(); id_set(ADD, 8, 0, 0, 1, 0, 16'h0042, 16'h0000, 0, 0, 1, 0, 0);
        exm_set(0, 0, 3, 16'h0009); wb_set(1, 3, 16'h0007);
        expect_out(1, 1, 0, 0, ADD, 7, 16'h0007, 16'h0002, 16'h0002, 0, 4'b0010);
        tick(); id_set(ADD, 9, 4, 0, 1, 0, 16'h0010, 16'h0000, 0, 0, 1, 0, 0);
        exm_set(1, 0, 0, 16'hffff);
        expect_out(1, 1, 0, 0, ADD, 8, 16'h0042, 16'h0000, 16'h0000, 0, 0);
        // A load in EX/MEM is not forwarded
        tick(); id_set(LW, 4, 5, 0, 1, 0, 16'h0100, 16'h0000, 16'h0004, 1, 1, 1, 0);
        exm_set(1, 1, 4, 16'h9999);
        expect_out(1, 1, 0, 0, ADD, 9, 16'h0010, 16'h0000, 16'h0000, 0, 0);
        // Load-use: one stall, one bubble, then MEM/WB data
        tick(); id_set(ADD, 6, 4, 2, 1, 1, 16'h0000, 16'h0022, 0, 0, 1, 0, 0);
        expect_out(1, 1, 1, 0, LW, 4, 16'h0100, 16'h0004, 16'h0000, 1, 0);
        tick(); id_set(ADD, 6, 4, 2, 1, 1, 16'h0000, 16'h0022, 0, 0, 1, 0, 0);
        exm_set(1, 1, 4, 16'hdead);
        exp_bubble(0);
        tick(); wb_set(1, 4, 16'h1234);
        expect_out(1, 1, 0, 0, ADD, 6, 16'h1234, 16'h0022, 16'h0022, 0, 4'b0010);
`else
        // No forwarding: dependent ADD waits through EX, EX/MEM and MEM/WB
        tick(); id_set(ADD, 1, 2, 3, 1, 1, 16'h0002, 16'h0003, 0, 0, 1, 0, 0);
        exp_bubble(0);
        tick(); id_set(ADD, 4, 1, 1, 1, 1, 16'h0000, 16'h0000, 0, 0, 1, 0, 0);
        expect_out(1, 1, 0, 0, ADD, 1, 16'h0002, 16'h0003, 16'h0003, 1, 0);
        tick(); id_set(ADD, 4, 1, 1, 1, 1, 16'h0000, 16'h0000, 0, 0, 1, 0, 0);
        exm_set(1, 0, 1, 16'h0005);
        exp_bubble(1);
        tick(); id_set(ADD, 4, 1, 1, 1, 1, 16'h0000, 16'h0000, 0, 0, 1, 0, 0);
        wb_set(1, 1, 16'h0005);
        exp_bubble(1);
        tick(); id_set(ADD, 4, 1, 1, 1, 1, 16'h0005, 16'h0005, 0, 0, 1, 0, 0);
        exp_bubble(0);
        tick();
        expect_out(1, 1, 0, 0, ADD, 4, 16'h0005, 16'h0005, 16'h0005, 0, 0);
`endif

        // Drain the scoreboard with a bounded wait
        for (int i = 0; i < 20; i++) begin
            if (exp_q.size() == 0) break;
            @(posedge clk);
        end
        #1;
        if (exp_q.size() != 0) begin
            n_total++;
            $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
